// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencing controller.
package pipe_hazard_ctrl_pkg;

  // Controller FSM: normal flow, or waiting for the data memory to acknowledge.
  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  // Register x0 is hard-wired zero and never creates a dependency.
  localparam logic [4:0] REG_ZERO = 5'd0;

  // Default number of MEM_WAIT cycles before an access is abandoned.
  localparam int TIMEOUT_DEFAULT = 64;

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Load-use comparator: flags an ID instruction that reads the destination
// of a load still sitting in EX.
module pipe_hazard_ctrl_hazard_detect
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic [4:0] i_id_rs1,
  input  logic [4:0] i_id_rs2,
  input  logic       i_id_use_rs1,
  input  logic       i_id_use_rs2,
  input  logic       i_ex_memread,
  input  logic [4:0] i_ex_rd,
  output logic       o_load_use
);

  logic w_hit_rs1;
  logic w_hit_rs2;

  // Compare each used source against the pending load destination.
  always_comb begin
    w_hit_rs1  = i_id_use_rs1 && (i_id_rs1 == i_ex_rd);
    w_hit_rs2  = i_id_use_rs2 && (i_id_rs2 == i_ex_rd);
    o_load_use = i_ex_memread && (i_ex_rd != REG_ZERO) && (w_hit_rs1 || w_hit_rs2);
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage core: memory-wait freeze,
// branch redirect flush and load-use bubble, with a stall-cycle counter.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       ID_rs1,
  input  logic [4:0]       ID_rs2,
  input  logic             ID_use_rs1,
  input  logic             ID_use_rs2,
  input  logic             ID_EX_MemRead,
  input  logic [4:0]       ID_EX_rd,
  input  logic             EX_branch_taken,
  input  logic             EX_MEM_MemRead,
  input  logic             EX_MEM_MemWrite,
  input  logic             dmem_ack,
  output logic             dmem_req,
  output logic             PC_en,
  output logic             IF_ID_en,
  output logic             ID_EX_en,
  output logic             EX_MEM_en,
  output logic             MEM_WB_en,
  output logic             IF_ID_flush,
  output logic             ID_EX_flush,
  output logic             EX_MEM_flush,
  output logic             MEM_WB_flush,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int WAIT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic              r_mem_err;
  logic [CNT_W-1:0]  r_stall_cnt;

  logic w_mem_op;
  logic w_timeout;
  logic w_freeze;
  logic w_load_use;

  pipe_hazard_ctrl_hazard_detect u_hazard_detect (
    .i_id_rs1     (ID_rs1),
    .i_id_rs2     (ID_rs2),
    .i_id_use_rs1 (ID_use_rs1),
    .i_id_use_rs2 (ID_use_rs2),
    .i_ex_memread (ID_EX_MemRead),
    .i_ex_rd      (ID_EX_rd),
    .o_load_use   (w_load_use)
  );

  // Memory-side status: pending access, expired wait, and whole-front freeze.
  always_comb begin
    w_mem_op  = EX_MEM_MemRead | EX_MEM_MemWrite;
    w_timeout = (r_state == MEM_WAIT) && (r_wait_cnt == WAIT_LAST) && !dmem_ack;
    w_freeze  = ((r_state == RUN) && w_mem_op && !dmem_ack) ||
                ((r_state == MEM_WAIT) && !dmem_ack && !w_timeout);
  end

  // Next-state: enter MEM_WAIT on an unacknowledged access, leave on ack or timeout.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RUN:      if (w_mem_op && !dmem_ack) w_state_nxt = MEM_WAIT;
      MEM_WAIT: if (dmem_ack || w_timeout) w_state_nxt = RUN;
      default:  w_state_nxt = RUN;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= RUN;
    else      r_state <= w_state_nxt;
  end

  // Wait counter: zero while running, so it restarts on every MEM_WAIT entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                      r_wait_cnt <= '0;
    else if (r_state == MEM_WAIT)  r_wait_cnt <= r_wait_cnt + 1'b1;
    else                           r_wait_cnt <= '0;
  end

  // Sticky timeout flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           r_mem_err <= 1'b0;
    else if (w_timeout) r_mem_err <= 1'b1;
  end

  // Saturating count of cycles in which the PC is held.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                             r_stall_cnt <= '0;
    else if (!PC_en && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 1'b1;
  end

  // Priority mux: reset, memory freeze, branch redirect, load-use bubble, normal flow.
  always_comb begin
    dmem_req     = (r_state == MEM_WAIT) ? 1'b1 : w_mem_op;
    PC_en        = 1'b1;
    IF_ID_en     = 1'b1;
    ID_EX_en     = 1'b1;
    EX_MEM_en    = 1'b1;
    MEM_WB_en    = 1'b1;
    IF_ID_flush  = 1'b0;
    ID_EX_flush  = 1'b0;
    EX_MEM_flush = 1'b0;
    MEM_WB_flush = w_timeout;
    if (!rst) begin
      dmem_req     = 1'b0;
      IF_ID_flush  = 1'b1;
      ID_EX_flush  = 1'b1;
      EX_MEM_flush = 1'b1;
      MEM_WB_flush = 1'b1;
    end else if (w_freeze) begin
      PC_en        = 1'b0;
      IF_ID_en     = 1'b0;
      ID_EX_en     = 1'b0;
      EX_MEM_en    = 1'b0;
      MEM_WB_flush = 1'b1;
    end else if (EX_branch_taken) begin
      // The ID instruction is wrong-path, so any load-use match is moot.
      IF_ID_flush  = 1'b1;
      ID_EX_flush  = 1'b1;
    end else if (w_load_use) begin
      PC_en        = 1'b0;
      IF_ID_en     = 1'b0;
      ID_EX_flush  = 1'b1;
    end
  end

  assign mem_err   = r_mem_err;
  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: per-cycle behavioural model plus
// hand-computed literal expectations for the directed scenarios.
module tb_pipe_hazard_ctrl;

  localparam int TO    = 4;
  localparam int CW    = 3;
  localparam int SMAX  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [4:0]    ID_rs1, ID_rs2, ID_EX_rd;
  logic          ID_use_rs1, ID_use_rs2, ID_EX_MemRead;
  logic          EX_branch_taken, EX_MEM_MemRead, EX_MEM_MemWrite, dmem_ack;
  logic          dmem_req, PC_en, IF_ID_en, ID_EX_en, EX_MEM_en, MEM_WB_en;
  logic          IF_ID_flush, ID_EX_flush, EX_MEM_flush, MEM_WB_flush, mem_err;
  logic [CW-1:0] stall_cnt;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Model state: whether an access is outstanding, how long it has waited,
  // the sticky error and the stall count; *_n are values for the next edge.
  int m_wait, m_waited, m_err, m_stall;
  int n_wait, n_waited, n_err, n_stall;

  pipe_hazard_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .ID_rs1(ID_rs1), .ID_rs2(ID_rs2), .ID_use_rs1(ID_use_rs1), .ID_use_rs2(ID_use_rs2),
    .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_rd(ID_EX_rd), .EX_branch_taken(EX_branch_taken),
    .EX_MEM_MemRead(EX_MEM_MemRead), .EX_MEM_MemWrite(EX_MEM_MemWrite), .dmem_ack(dmem_ack),
    .dmem_req(dmem_req), .PC_en(PC_en), .IF_ID_en(IF_ID_en), .ID_EX_en(ID_EX_en),
    .EX_MEM_en(EX_MEM_en), .MEM_WB_en(MEM_WB_en), .IF_ID_flush(IF_ID_flush),
    .ID_EX_flush(ID_EX_flush), .EX_MEM_flush(EX_MEM_flush), .MEM_WB_flush(MEM_WB_flush),
    .mem_err(mem_err), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s (cycle %0d): got %0d, required %0d", name, cyc, act, exp);
    end
  endtask

  task automatic idle();
    ID_rs1 = 0; ID_rs2 = 0; ID_use_rs1 = 0; ID_use_rs2 = 0;
    ID_EX_MemRead = 0; ID_EX_rd = 0; EX_branch_taken = 0;
    EX_MEM_MemRead = 0; EX_MEM_MemWrite = 0; dmem_ack = 0;
  endtask

  task automatic model_reset();
    m_wait = 0; m_waited = 0; m_err = 0; m_stall = 0;
  endtask

  // Compare outputs against the model at mid-cycle and prepare the next model state.
  task automatic eval();
    bit mop, lu, tmo, frz;
    bit e_req, e_pc, e_ifid, e_idex, e_exmem, e_memwb;
    bit f_ifid, f_idex, f_exmem, f_memwb;
    logic [10:0] got, exp;
    @(negedge clk);
    mop = EX_MEM_MemRead || EX_MEM_MemWrite;
    lu  = ID_EX_MemRead && (ID_EX_rd != 0) &&
          ((ID_use_rs1 && ID_rs1 == ID_EX_rd) || (ID_use_rs2 && ID_rs2 == ID_EX_rd));
    tmo = (m_wait != 0) && (m_waited == TO - 1) && !dmem_ack;
    frz = (m_wait != 0) ? (!dmem_ack && !tmo) : (mop && !dmem_ack);
    e_req = (m_wait != 0) || mop;
    {e_pc, e_ifid, e_idex, e_exmem, e_memwb} = 5'b11111;
    {f_ifid, f_idex, f_exmem, f_memwb} = {3'b000, tmo};
    if (!rst) begin
      e_req = 0;
      {f_ifid, f_idex, f_exmem, f_memwb} = 4'b1111;
    end else if (frz) begin
      {e_pc, e_ifid, e_idex, e_exmem} = 4'b0000;
      f_memwb = 1;
    end else if (EX_branch_taken) begin
      f_ifid = 1; f_idex = 1;
    end else if (lu) begin
      e_pc = 0; e_ifid = 0; f_idex = 1;
    end
    exp = {e_req, e_pc, e_ifid, e_idex, e_exmem, e_memwb, f_ifid, f_idex, f_exmem, f_memwb, 1'(m_err)};
    got = {dmem_req, PC_en, IF_ID_en, ID_EX_en, EX_MEM_en, MEM_WB_en,
           IF_ID_flush, ID_EX_flush, EX_MEM_flush, MEM_WB_flush, mem_err};
    chk("model_outputs", int'(got), int'(exp));
    chk("model_stall_cnt", int'(stall_cnt), m_stall);
    if (!rst) begin
      n_wait = 0; n_waited = 0; n_err = 0; n_stall = 0;
    end else begin
      n_stall  = (!e_pc && m_stall < SMAX) ? m_stall + 1 : m_stall;
      n_err    = (m_err != 0 || tmo) ? 1 : 0;
      n_wait   = m_wait;
      n_waited = m_waited;
      if (m_wait != 0) begin
        if (dmem_ack || tmo) n_wait = 0;
        else                 n_waited = m_waited + 1;
      end else if (mop && !dmem_ack) begin
        n_wait = 1; n_waited = 0;
      end
    end
  endtask

  task automatic adv();
    @(posedge clk);
    m_wait = n_wait; m_waited = n_waited; m_err = n_err; m_stall = n_stall;
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    rst = 0;
    model_reset();
    #1;
    chk("reset_dmem_req", int'(dmem_req), 0);
    chk("reset_flushes", int'({IF_ID_flush, ID_EX_flush, EX_MEM_flush, MEM_WB_flush}), 15);
    chk("reset_enables", int'({PC_en, IF_ID_en, ID_EX_en, EX_MEM_en, MEM_WB_en}), 31);
    chk("reset_stall_cnt", int'(stall_cnt), 0);
    chk("reset_mem_err", int'(mem_err), 0);
    eval(); adv();
    rst = 1;
  endtask

  initial begin
    idle();
    model_reset();
    #2;
    do_reset();
    idle(); eval(); adv();

    // Load-use: one cycle of stall, then the counter reads 1.
    ID_EX_MemRead = 1; ID_EX_rd = 5; ID_rs1 = 5; ID_use_rs1 = 1;
    eval();
    chk("lu_PC_en", int'(PC_en), 0);
    chk("lu_IF_ID_en", int'(IF_ID_en), 0);
    chk("lu_ID_EX_flush", int'(ID_EX_flush), 1);
    adv();
    idle(); eval();
    chk("lu_stall_cnt", int'(stall_cnt), 1);
    chk("lu_after_PC_en", int'(PC_en), 1);
    adv();

    // Same match against x0: no stall.
    ID_EX_MemRead = 1; ID_EX_rd = 0; ID_rs1 = 0; ID_use_rs1 = 1;
    eval();
    chk("lu_x0_PC_en", int'(PC_en), 1);
    chk("lu_x0_ID_EX_flush", int'(ID_EX_flush), 0);
    adv();

    // Match through rs2 only.
    idle(); ID_EX_MemRead = 1; ID_EX_rd = 9; ID_rs2 = 9; ID_use_rs2 = 1; ID_rs1 = 9;
    eval();
    chk("lu_rs2_PC_en", int'(PC_en), 0);
    adv();

    // Branch together with load-use: flush wins, no stall.
    idle(); ID_EX_MemRead = 1; ID_EX_rd = 5; ID_rs1 = 5; ID_use_rs1 = 1; EX_branch_taken = 1;
    eval();
    chk("br_PC_en", int'(PC_en), 1);
    chk("br_flushes", int'({IF_ID_flush, ID_EX_flush}), 3);
    chk("br_IF_ID_en", int'(IF_ID_en), 1);
    adv();
    idle(); eval();
    chk("br_stall_cnt", int'(stall_cnt), 2);
    adv();

    // Store acknowledged in the request cycle.
    EX_MEM_MemWrite = 1; dmem_ack = 1;
    eval();
    chk("st_dmem_req", int'(dmem_req), 1);
    chk("st_PC_en", int'(PC_en), 1);
    chk("st_MEM_WB_flush", int'(MEM_WB_flush), 0);
    adv();
    idle(); eval();
    chk("st_stays_run_req", int'(dmem_req), 0);
    adv();

    // Load acknowledged on the 4th request cycle; branch during freeze is ignored.
    do_reset();
    idle(); EX_MEM_MemRead = 1;
    for (int i = 0; i < 3; i++) begin
      EX_branch_taken = (i == 1);
      eval();
      chk("ld_wait_req", int'(dmem_req), 1);
      chk("ld_wait_PC_en", int'(PC_en), 0);
      chk("ld_wait_MEM_WB_flush", int'(MEM_WB_flush), 1);
      chk("ld_wait_IF_ID_flush", int'(IF_ID_flush), 0);
      adv();
    end
    EX_branch_taken = 0; dmem_ack = 1;
    eval();
    chk("ld_ack_req", int'(dmem_req), 1);
    chk("ld_ack_enables", int'({PC_en, IF_ID_en, ID_EX_en, EX_MEM_en, MEM_WB_en}), 31);
    chk("ld_ack_MEM_WB_flush", int'(MEM_WB_flush), 0);
    adv();
    idle(); eval();
    chk("ld_stall_cnt", int'(stall_cnt), 3);
    chk("ld_done_req", int'(dmem_req), 0);
    adv();

    // No ack: abandoned on the 4th MEM_WAIT cycle.
    do_reset();
    idle(); EX_MEM_MemRead = 1;
    for (int i = 0; i < 4; i++) begin
      eval();
      chk("to_wait_PC_en", int'(PC_en), 0);
      adv();
    end
    eval();
    chk("to_PC_en", int'(PC_en), 1);
    chk("to_MEM_WB_flush", int'(MEM_WB_flush), 1);
    chk("to_req", int'(dmem_req), 1);
    chk("to_err_not_yet", int'(mem_err), 0);
    adv();
    idle();
    for (int i = 0; i < 3; i++) begin
      eval();
      chk("to_mem_err_sticky", int'(mem_err), 1);
      chk("to_back_in_run_req", int'(dmem_req), 0);
      adv();
    end
    chk("to_stall_cnt", int'(stall_cnt), 4);

    // Reset while waiting: request drops immediately, counters clear.
    EX_MEM_MemRead = 1;
    eval(); adv();
    eval(); adv();
    rst = 0;
    model_reset();
    #1;
    chk("rw_dmem_req", int'(dmem_req), 0);
    chk("rw_stall_cnt", int'(stall_cnt), 0);
    chk("rw_mem_err", int'(mem_err), 0);
    eval(); adv();
    rst = 1; idle();
    eval();
    chk("rw_run_enables", int'({PC_en, IF_ID_en, ID_EX_en, EX_MEM_en, MEM_WB_en}), 31);
    chk("rw_run_req", int'(dmem_req), 0);
    adv();

    // Counter saturation.
    ID_EX_MemRead = 1; ID_EX_rd = 3; ID_rs2 = 3; ID_use_rs2 = 1;
    for (int i = 0; i < 10; i++) begin
      eval(); adv();
    end
    idle(); eval();
    chk("sat_stall_cnt", int'(stall_cnt), SMAX);
    adv();

    // Mixed traffic against the model.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      ID_rs1          = 5'($urandom_range(0, 3));
      ID_rs2          = 5'($urandom_range(0, 3));
      ID_EX_rd        = 5'($urandom_range(0, 3));
      ID_use_rs1      = 1'($urandom_range(0, 1));
      ID_use_rs2      = 1'($urandom_range(0, 1));
      ID_EX_MemRead   = 1'($urandom_range(0, 1));
      EX_branch_taken = ($urandom_range(0, 4) == 0);
      if (m_wait == 0) begin
        EX_MEM_MemRead  = ($urandom_range(0, 3) == 0);
        EX_MEM_MemWrite = ($urandom_range(0, 4) == 0);
      end
      dmem_ack = ($urandom_range(0, 3) == 0);
      eval(); adv();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage core.
- Drives the load-enable and flush of the IF/ID, ID/EX, EX/MEM and MEM/WB registers and the PC enable.
- Detects load-use hazards and branch redirects.
- Runs the req/ack handshake with a variable-latency data memory; MEM/WB receives a bubble while the MEM stage waits.

Parameters:
- TIMEOUT, 64, maximum cycles in MEM_WAIT before a forced abort (>=2).
- CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-low (0 = reset).
- ID_rs1  in  5  source register 1 of the instruction in ID.
- ID_rs2  in  5  source register 2 of the instruction in ID.
- ID_use_rs1  in  1  ID instruction reads rs1.
- ID_use_rs2  in  1  ID instruction reads rs2.
- ID_EX_MemRead  in  1  instruction in EX is a load.
- ID_EX_rd  in  5  destination of the instruction in EX.
- EX_branch_taken  in  1  EX resolves a taken branch/jump this cycle.
- EX_MEM_MemRead  in  1  instruction in MEM is a load.
- EX_MEM_MemWrite  in  1  instruction in MEM is a store.
- dmem_ack  in  1  data memory completes the current access this cycle.
- dmem_req  out  1  data memory access request.
- PC_en  out  1  PC load enable.
- IF_ID_en, ID_EX_en, EX_MEM_en, MEM_WB_en  out  1 each  pipeline register load enables.
- IF_ID_flush, ID_EX_flush, EX_MEM_flush, MEM_WB_flush  out  1 each  load zeros (bubble); flush overrides en.
- mem_err  out  1  sticky: a memory access timed out.
- stall_cnt  out  CNT_W  cycles with PC_en=0, saturating.

Behaviour:
- Async reset (rst=0):
  - FSM=RUN; wait_cnt=0; mem_err=0; stall_cnt=0.
  - While in reset, all enables=1, all flushes=1, dmem_req=0.
- FSM states: RUN, MEM_WAIT. Control outputs are combinational from state plus inputs. mem_err and stall_cnt are registered.
- mem_op = EX_MEM_MemRead | EX_MEM_MemWrite.
- dmem_req = mem_op in RUN, 1 in MEM_WAIT. It is held high until ack or timeout.
- Memory stall (highest priority), active when (RUN & mem_op & !dmem_ack) or (MEM_WAIT & !dmem_ack & !timeout):
  - PC_en = IF_ID_en = ID_EX_en = EX_MEM_en = 0.
  - MEM_WB_flush = 1.
  - Branch and load-use are ignored; they are re-evaluated once the freeze ends.
- Transitions:
  - RUN -> MEM_WAIT when mem_op & !dmem_ack.
  - MEM_WAIT -> RUN on dmem_ack or timeout.
  - An ack in the same cycle as the request stays in RUN with zero stall.
- Completion cycle (ack):
  - All stages advance normally; MEM_WB loads memread_data that cycle.
  - No re-request occurs for the same instruction.
  - A new mem_op in EX_MEM next cycle starts a fresh request.
- Timeout:
  - wait_cnt counts cycles in MEM_WAIT (reset on entry). timeout = (wait_cnt == TIMEOUT-1) & !dmem_ack.
  - On timeout: advance as on ack, but MEM_WB_flush=1 so there is no writeback; set mem_err.
  - mem_err is cleared only by reset.
- Branch (no memory stall, EX_branch_taken=1):
  - IF_ID_flush = ID_EX_flush = 1; PC_en = 1.
  - Overrides load-use, because the ID instruction is wrong-path.
- Load-use (no memory stall, no branch): condition is ID_EX_MemRead & ID_EX_rd != 0 & ((ID_use_rs1 & ID_rs1 == ID_EX_rd) | (ID_use_rs2 & ID_rs2 == ID_EX_rd)).
  - PC_en = IF_ID_en = 0; ID_EX_flush = 1.
  - The later stages advance. Exactly one bubble is inserted, because the load moves to MEM next cycle.
- Otherwise: all enables = 1, all flushes = 0.
- stall_cnt increments each cycle PC_en=0 and saturates at 2^CNT_W - 1.
- Reset mid-MEM_WAIT: the FSM returns to RUN immediately and dmem_req drops asynchronously.

Decomposition:
- Shared package holds:
  - state encoding typedef (RUN=0, MEM_WAIT=1);
  - REG_ZERO=5'd0;
  - the default TIMEOUT constant.
- One natural sub-module: hazard_detect, the combinational load-use comparator. The FSM, counters and priority mux stay in pipe_hazard_ctrl.

Test Plan:
- Load-use: ID_EX_MemRead=1, ID_EX_rd=5, ID_rs1=5, ID_use_rs1=1 -> PC_en=0, IF_ID_en=0, ID_EX_flush=1 for one cycle, stall_cnt=1. Same stimulus with rd=0 -> no stall.
- Branch plus load-use in the same cycle -> IF_ID_flush=ID_EX_flush=1, PC_en=1, no stall.
- Store in MEM with dmem_ack same cycle -> dmem_req=1, no freeze, FSM stays RUN.
- Load in MEM, ack after 3 cycles:
  - dmem_req high 4 cycles, PC_en=0 for 3 cycles, MEM_WB_flush=1 for 3 cycles;
  - on the 4th cycle everything is enabled and MEM_WB_flush=0; stall_cnt=3.
- No ack with TIMEOUT=4 -> after 4 cycles in MEM_WAIT: mem_err=1, MEM_WB_flush=1, pipeline advances, FSM=RUN; mem_err stays 1.
- rst=0 asserted while in MEM_WAIT -> dmem_req=0 immediately, stall_cnt=0, mem_err=0. After release, with mem_op=0 -> RUN, all enables=1.
